// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - shared types and encodings for the PLIC interrupt gateway
package plic_pkg;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_t;

  localparam logic PLIC_LEVEL = 1'b0;
  localparam logic PLIC_EDGE  = 1'b1;

endpackage

// File: rtl/plic_gateway_cell.sv
// rtl/plic_gateway_cell.sv - one source's gateway: FSM, edge queue counter, edge detector
// Optional PLIC_GATEWAY_SYNC_EN adds a 2-flop input synchronizer ahead of the mode logic.
module plic_gateway_cell
  import plic_pkg::*;
#(
  parameter int unsigned ID                = 1,
  parameter int unsigned MAX_PENDING_COUNT = 8,
  parameter int unsigned ID_BITS           = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               src_i,
  input  logic               edge_lvl_i,
  input  logic               claim_i,
  input  logic [ID_BITS-1:0] claim_id_i,
  input  logic               complete_i,
  input  logic [ID_BITS-1:0] complete_id_i,
  output logic               ip_o
);

  localparam int unsigned CNT_BITS = $clog2(MAX_PENDING_COUNT + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_PENDING_COUNT);
  localparam logic [ID_BITS-1:0] MY_ID = ID_BITS'(ID);

  gw_state_t           state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                src_s, src_dly_q, src_edge;
  logic                inc, dec;
  logic                claim_hit, complete_hit;
  logic                ip_q;

`ifdef PLIC_GATEWAY_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], src_i};
  end

  assign src_s = sync_q[1];
`else
  assign src_s = src_i;
`endif

  assign src_edge     = src_s & ~src_dly_q;
  assign claim_hit    = claim_i && (claim_id_i == MY_ID);
  assign complete_hit = complete_i && (complete_id_i == MY_ID);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc     = 1'b0;
    dec     = 1'b0;
    if (edge_lvl_i == PLIC_LEVEL) begin
      cnt_d = '0;
    end else begin
      // An edge seen in IDLE with an empty queue is forwarded at once: inc and dec cancel.
      inc   = src_edge && (cnt_q < CNT_MAX);
      dec   = (state_q == GW_IDLE) && ((cnt_q != '0) || src_edge);
      cnt_d = cnt_q + CNT_BITS'(inc) - CNT_BITS'(dec);
    end
    case (state_q)
      GW_IDLE: begin
        if ((edge_lvl_i == PLIC_EDGE) ? dec : src_s) state_d = GW_PENDING;
      end
      GW_PENDING: begin
        if (claim_hit) state_d = GW_CLAIMED;
      end
      GW_CLAIMED: begin
        if (complete_hit) state_d = GW_IDLE;
      end
      default: state_d = GW_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= GW_IDLE;
      cnt_q     <= '0;
      src_dly_q <= 1'b0;
      ip_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_dly_q <= src_s;
      ip_q      <= (state_d == GW_PENDING);
    end
  end

  assign ip_o = ip_q;

endmodule

// File: rtl/plic_gateway.sv
// rtl/plic_gateway.sv - PLIC interrupt gateway array, one cell per source
// Optional PLIC_GATEWAY_SYNC_EN synchronizes src_i inside each cell.
module plic_gateway
  import plic_pkg::*;
#(
  parameter int unsigned SOURCES           = 16,
  parameter int unsigned MAX_PENDING_COUNT = 8,
  parameter int unsigned SOURCES_BITS      = $clog2(SOURCES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [SOURCES-1:0]      src_i,
  input  logic [SOURCES-1:0]      edge_lvl_i,
  input  logic                    claim_i,
  input  logic [SOURCES_BITS-1:0] claim_id_i,
  input  logic                    complete_i,
  input  logic [SOURCES_BITS-1:0] complete_id_i,
  output logic [SOURCES-1:0]      ip_o
);

  // Source k carries ID k+1; ID 0 and IDs above SOURCES match no cell.
  for (genvar k = 0; k < SOURCES; k++) begin : g_cell
    plic_gateway_cell #(
      .ID                (k + 1),
      .MAX_PENDING_COUNT (MAX_PENDING_COUNT),
      .ID_BITS           (SOURCES_BITS)
    ) u_cell (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .src_i         (src_i[k]),
      .edge_lvl_i    (edge_lvl_i[k]),
      .claim_i       (claim_i),
      .claim_id_i    (claim_id_i),
      .complete_i    (complete_i),
      .complete_id_i (complete_id_i),
      .ip_o          (ip_o[k])
    );
  end

endmodule

// File: tb/tb_plic_gateway.sv
// tb/tb_plic_gateway.sv - self-checking bench for plic_gateway (default build)
module tb_plic_gateway;

  localparam int SOURCES = 16;
  localparam int SB      = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [SOURCES-1:0] src = '0;
  logic [SOURCES-1:0] edge_lvl = '0;
  logic               claim = 1'b0;
  logic [SB-1:0]      claim_id = '0;
  logic               complete = 1'b0;
  logic [SB-1:0]      complete_id = '0;
  logic [SOURCES-1:0] ip;

  int n_checks = 0;
  int n_pass   = 0;

  logic [SOURCES-1:0] exp_q[$];
  string              name_q[$];

  typedef struct {
    logic [SOURCES-1:0] src;
    logic [SOURCES-1:0] lvl;
    logic               cl;
    logic [SB-1:0]      cl_id;
    logic               co;
    logic [SB-1:0]      co_id;
    logic [SOURCES-1:0] exp_ip;
    string              name;
  } vec_t;

  vec_t tbl[$];

  plic_gateway dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .src_i         (src),
    .edge_lvl_i    (edge_lvl),
    .claim_i       (claim),
    .claim_id_i    (claim_id),
    .complete_i    (complete),
    .complete_id_i (complete_id),
    .ip_o          (ip)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [15:0] s, logic [15:0] l, logic c, int cid,
                              logic d, int did, logic [15:0] e, string n);
    vec_t v;
    v.src = s; v.lvl = l; v.cl = c; v.cl_id = SB'(cid);
    v.co = d; v.co_id = SB'(did); v.exp_ip = e; v.name = n;
    return v;
  endfunction

  task automatic check(string name, logic [SOURCES-1:0] act, logic [SOURCES-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: ip_o=%h required=%h", name, act, exp);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(vec_t v);
    @(negedge clk);
    src = v.src; edge_lvl = v.lvl;
    claim = v.cl; claim_id = v.cl_id;
    complete = v.co; complete_id = v.co_id;
    exp_q.push_back(v.exp_ip);
    name_q.push_back(v.name);
    @(posedge clk);
    #1;
    check(name_q.pop_front(), ip, exp_q.pop_front());
  endtask

  initial begin
    // Level path on source 2 (ID 3)
    tbl.push_back(mk(16'h0004, 16'h0, 0, 0, 0, 0, 16'h0004, "lvl_assert"));
    tbl.push_back(mk(16'h0004, 16'h0, 1, 3, 0, 0, 16'h0000, "lvl_claim"));
    tbl.push_back(mk(16'h0004, 16'h0, 0, 0, 1, 3, 16'h0000, "lvl_complete_idle"));
    tbl.push_back(mk(16'h0004, 16'h0, 0, 0, 0, 0, 16'h0004, "lvl_repend"));
    tbl.push_back(mk(16'h0000, 16'h0, 0, 0, 0, 0, 16'h0004, "lvl_persist"));
    tbl.push_back(mk(16'h0000, 16'h0, 1, 3, 0, 0, 16'h0000, "lvl_claim2"));
    tbl.push_back(mk(16'h0000, 16'h0, 0, 0, 1, 3, 16'h0000, "lvl_complete2"));
    tbl.push_back(mk(16'h0000, 16'h0, 0, 0, 0, 0, 16'h0000, "lvl_quiet"));
    // Ignored IDs with only source 1 (ID 2) pending
    tbl.push_back(mk(16'h0002, 16'h0, 0, 0, 0, 0, 16'h0002, "id_pend"));
    tbl.push_back(mk(16'h0000, 16'h0, 1, 0, 0, 0, 16'h0002, "id_claim0"));
    tbl.push_back(mk(16'h0000, 16'h0, 1, 5, 0, 0, 16'h0002, "id_claim5"));
    tbl.push_back(mk(16'h0000, 16'h0, 1, 17, 0, 0, 16'h0002, "id_claim17"));
    tbl.push_back(mk(16'h0000, 16'h0, 0, 0, 1, 2, 16'h0002, "id_complete_unclaimed"));
    tbl.push_back(mk(16'h0000, 16'h0, 1, 2, 0, 0, 16'h0000, "id_claim2"));
    tbl.push_back(mk(16'h0000, 16'h0, 0, 0, 1, 2, 16'h0000, "id_complete2"));
    // Simultaneous claim ID 1 and complete ID 4
    tbl.push_back(mk(16'h0008, 16'h0, 0, 0, 0, 0, 16'h0008, "sim_pend3"));
    tbl.push_back(mk(16'h0000, 16'h0, 1, 4, 0, 0, 16'h0000, "sim_claim4"));
    tbl.push_back(mk(16'h0001, 16'h0, 0, 0, 0, 0, 16'h0001, "sim_pend0"));
    tbl.push_back(mk(16'h0000, 16'h0, 1, 1, 1, 4, 16'h0000, "sim_both"));
    tbl.push_back(mk(16'h0009, 16'h0, 0, 0, 0, 0, 16'h0008, "sim_states"));
    tbl.push_back(mk(16'h0000, 16'h0, 1, 4, 1, 1, 16'h0000, "sim_cleanup"));
    tbl.push_back(mk(16'h0000, 16'h0, 0, 0, 1, 4, 16'h0000, "sim_cleanup2"));
    tbl.push_back(mk(16'h0000, 16'h0, 0, 0, 0, 0, 16'h0000, "sim_quiet"));

    repeat (2) @(posedge clk);
    #1 check("reset_ip", ip, '0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Edge queue on source 0: 10 pulses, then 9 claim/complete rounds
    for (int p = 0; p < 10; p++) begin
      step(mk(16'h0001, 16'h0001, 0, 0, 0, 0, 16'h0001, $sformatf("edge_pulse_hi%0d", p)));
      step(mk(16'h0000, 16'h0001, 0, 0, 0, 0, 16'h0001, $sformatf("edge_pulse_lo%0d", p)));
    end
    for (int r = 0; r < 9; r++) begin
      step(mk(16'h0, 16'h0001, 1, 1, 0, 0, 16'h0000, $sformatf("edge_claim%0d", r)));
      step(mk(16'h0, 16'h0001, 0, 0, 1, 1, 16'h0000, $sformatf("edge_complete%0d", r)));
      step(mk(16'h0, 16'h0001, 0, 0, 0, 0, (r < 8) ? 16'h0001 : 16'h0000,
              $sformatf("edge_round%0d", r)));
    end
    for (int q = 0; q < 3; q++)
      step(mk(16'h0, 16'h0001, 0, 0, 0, 0, 16'h0000, "edge_drained"));

    // Source 5 (ID 6) edge mode CLAIMED with 3 queued, source 2 level pending
    step(mk(16'h0020, 16'h0020, 0, 0, 0, 0, 16'h0020, "rst_pend5"));
    for (int p = 0; p < 3; p++) begin
      step(mk(16'h0000, 16'h0020, 0, 0, 0, 0, 16'h0020, "rst_q_lo"));
      step(mk(16'h0020, 16'h0020, 0, 0, 0, 0, 16'h0020, "rst_q_hi"));
    end
    step(mk(16'h0004, 16'h0020, 1, 6, 0, 0, 16'h0004, "rst_claim6"));
    #2;
    src = 16'h0080; edge_lvl = 16'h00A0;
    claim = 1'b0; complete = 1'b0;
    rst_n = 1'b0;
    #1 check("rst_async_clear", ip, '0);
    @(posedge clk);
    #1 check("rst_held", ip, '0);
    @(negedge clk) rst_n = 1'b1;
    // Source 7 held high across release counts as an edge; source 5 needs no complete
    step(mk(16'h0080, 16'h00A0, 0, 0, 0, 0, 16'h0080, "rst_edge_release"));
    step(mk(16'h0080, 16'h00A0, 1, 8, 0, 0, 16'h0000, "rst_claim8"));
    step(mk(16'h0080, 16'h00A0, 0, 0, 1, 8, 16'h0000, "rst_complete8"));
    for (int q = 0; q < 3; q++)
      step(mk(16'h0080, 16'h00A0, 0, 0, 0, 0, 16'h0000, "rst_no_requeue"));
    step(mk(16'h0020, 16'h00A0, 0, 0, 0, 0, 16'h0020, "rst_src5_fresh"));
    step(mk(16'h0000, 16'h00A0, 1, 6, 0, 0, 16'h0000, "rst_claim6b"));
    step(mk(16'h0000, 16'h00A0, 0, 0, 1, 6, 16'h0000, "rst_complete6b"));
    step(mk(16'h0000, 16'h00A0, 0, 0, 0, 0, 16'h0000, "rst_src5_empty"));

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
